// File: rtl/movegen_sequencer.sv
// Move-generation sequencer: resets the square array, waits for it to settle,
// then drains every square FIFO in index order and streams the unpacked moves.
//
// state  | meaning
// IDLE   | waiting for start
// PULSE  | board_reset high for one cycle
// WAIT   | settle counter running, waiting for hold to clear or timeout
// SCAN   | testing sq_empty[ptr], one cycle per empty square
// READ   | sq_rden[ptr] high for one cycle
// LAT    | waiting for read data, then capturing the 8-slot entry
// UNPACK | emitting valid slots 7..0 on the mv stream
// FIN    | gen_done pulse
module movegen_sequencer #(
  parameter int NSQ        = 64,
  parameter int SETTLE_CYC = 16,
  parameter int MAXWAIT    = 255,
  parameter int RDLAT      = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   board_reset,
  input  logic [NSQ-1:0]         sq_hold,
  input  logic [NSQ-1:0]         sq_empty,
  output logic [NSQ-1:0]         sq_rden,
  output logic [$clog2(NSQ)-1:0] sq_sel,
  input  logic [151:0]           sq_data,
  output logic [18:0]            mv_data,
  output logic                   mv_valid,
  input  logic                   mv_ready,
  output logic                   busy,
  output logic                   gen_done,
  output logic [9:0]             move_count,
  output logic                   err_timeout
);

  localparam int IW = $clog2(NSQ);
  localparam int WW = $clog2(MAXWAIT + 1);
  localparam int LW = (RDLAT > 1) ? $clog2(RDLAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PULSE, S_WAIT, S_SCAN, S_READ, S_LAT, S_UNPACK, S_FIN
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [WW-1:0]   wait_cnt;
  logic [LW-1:0]   lat_cnt;
  logic [2:0]      slot_idx;
  logic [151:0]    slots;
  logic [18:0]     cur_slot;

  // ptr is a register, so the mux select is registered as well
  assign sq_sel = ptr;

  // slot currently being examined in UNPACK
  assign cur_slot = slots[19*slot_idx +: 19];

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wait_cnt    <= '0;
      lat_cnt     <= '0;
      slot_idx    <= '0;
      slots       <= '0;
      board_reset <= 1'b0;
      sq_rden     <= '0;
      mv_data     <= '0;
      mv_valid    <= 1'b0;
      busy        <= 1'b0;
      gen_done    <= 1'b0;
      move_count  <= '0;
      err_timeout <= 1'b0;
    end else if (abort) begin
      // FIFO contents are left as they are; the next board_reset clears them
      state       <= S_IDLE;
      board_reset <= 1'b0;
      sq_rden     <= '0;
      mv_valid    <= 1'b0;
      busy        <= 1'b0;
      gen_done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_PULSE;
            board_reset <= 1'b1;
            busy        <= 1'b1;
            move_count  <= '0;
            err_timeout <= 1'b0;
            ptr         <= '0;
          end
        end
        S_PULSE: begin
          board_reset <= 1'b0;
          wait_cnt    <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt >= WW'(SETTLE_CYC) && !(|sq_hold)) begin
            state <= S_SCAN;
          end else if (wait_cnt == WW'(MAXWAIT)) begin
            err_timeout <= 1'b1;
            state       <= S_SCAN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SCAN: begin
          if (!sq_empty[ptr]) begin
            sq_rden <= NSQ'(1) << ptr;
            state   <= S_READ;
          end else if (ptr == IW'(NSQ - 1)) begin
            gen_done <= 1'b1;
            state    <= S_FIN;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_READ: begin
          sq_rden <= '0;
          lat_cnt <= '0;
          state   <= S_LAT;
        end
        S_LAT: begin
          if (lat_cnt == LW'(RDLAT - 1)) begin
            slots    <= sq_data;
            slot_idx <= 3'd7;
            state    <= S_UNPACK;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_UNPACK: begin
          // a valid slot takes one cycle to present, then waits for the handshake
          if (mv_valid) begin
            if (mv_ready) begin
              mv_valid <= 1'b0;
              if (move_count != 10'h3FF) move_count <= move_count + 10'd1;
              if (slot_idx == 3'd0) state <= S_SCAN;
              else slot_idx <= slot_idx - 3'd1;
            end
          end else if (cur_slot[18]) begin
            if (slot_idx == 3'd0) state <= S_SCAN;
            else slot_idx <= slot_idx - 3'd1;
          end else begin
            mv_valid <= 1'b1;
            mv_data  <= cur_slot;
          end
        end
        S_FIN: begin
          gen_done <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_movegen_sequencer.sv
// Bench for movegen_sequencer: behavioural square array, expected move stream
// built from the loaded board, and per-cycle stream checks.
module tb_movegen_sequencer;

  localparam int NSQ = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort;
  logic          board_reset;
  logic [NSQ-1:0] sq_hold, sq_empty, sq_rden;
  logic [5:0]    sq_sel;
  logic [151:0]  sq_data;
  logic [18:0]   mv_data;
  logic          mv_valid, mv_ready;
  logic          busy, gen_done;
  logic [9:0]    move_count;
  logic          err_timeout;

  always #5 clk = ~clk;

  movegen_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .board_reset(board_reset), .sq_hold(sq_hold), .sq_empty(sq_empty),
    .sq_rden(sq_rden), .sq_sel(sq_sel), .sq_data(sq_data),
    .mv_data(mv_data), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .busy(busy), .gen_done(gen_done), .move_count(move_count),
    .err_timeout(err_timeout)
  );

  typedef struct {
    int           sq;
    logic [151:0] d;
  } ent_t;

  ent_t        cfg[$];
  ent_t        fifo[$];
  logic [18:0] exp_q[$];
  logic [18:0] got[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int br_cnt = 0, br_cyc = 0, gd_cnt = 0, gd_cyc = 0, rden_cnt = 0, stall_cnt = 0;
  int model_cnt = 0;
  int rd_pend = -1;
  bit br_pend = 0;
  int mode = 0;
  int stall_left = 0;
  int hold_left = 0;
  bit pv = 0, pr = 0, pab = 0;
  logic [18:0] pd = '0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [151:0] blank_entry();
    logic [151:0] e;
    e = {8{19'h40000}};
    return e;
  endfunction

  function automatic int sat(input int n);
    return (n > 1023) ? 1023 : n;
  endfunction

  // expected stream: squares ascending, entries in load order, slots 7 down to 0
  task automatic build_expected();
    logic [18:0] s;
    exp_q.delete();
    for (int q = 0; q < NSQ; q++)
      foreach (cfg[j])
        if (cfg[j].sq == q)
          for (int k = 7; k >= 0; k--) begin
            s = cfg[j].d[19*k +: 19];
            if (!s[18]) exp_q.push_back(s);
          end
  endtask

  // square array model: reloads on board_reset, one-cycle read latency
  initial begin
    sq_empty = '1;
    sq_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (br_pend) begin
        fifo = cfg;
        br_pend = 0;
      end
      if (rd_pend >= 0) begin
        sq_data = '0;
        for (int j = 0; j < fifo.size(); j++)
          if (fifo[j].sq == rd_pend) begin
            sq_data = fifo[j].d;
            fifo.delete(j);
            break;
          end
        rd_pend = -1;
      end
      sq_empty = '1;
      foreach (fifo[j]) sq_empty[fifo[j].sq] = 1'b0;
    end
  end

  // consumer ready and hold-release driver
  initial begin
    mv_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: mv_ready = 1'b1;
        1: mv_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (got.size() == 1 && mv_valid && stall_left > 0) begin
            mv_ready = 1'b0;
            stall_left--;
          end else mv_ready = 1'b1;
        end
        default: mv_ready = 1'b0;
      endcase
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) sq_hold = '0;
      end
    end
  end

  initial forever begin
    @(negedge reset_n);
    pv = 0;
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset_n) begin
      if (board_reset) begin
        br_cnt++;
        br_cyc = cyc;
        br_pend = 1;
        build_expected();
        model_cnt = 0;
      end
      if (sq_rden != '0) begin
        rden_cnt++;
        check_eq("rden_onehot", 64'($countones(sq_rden)), 64'd1);
        check_eq("rden_matches_sel", 64'(sq_rden), 64'(NSQ'(1) << sq_sel));
        check_eq("rden_not_empty", 64'(sq_empty[sq_sel]), 64'd0);
        rd_pend = int'(sq_sel);
      end
      if (pv && !pr && !pab) begin
        stall_cnt++;
        check_eq("hold_valid", 64'(mv_valid), 64'd1);
        check_eq("hold_data", 64'(mv_data), 64'(pd));
      end
      if (mv_valid && mv_ready) begin
        got.push_back(mv_data);
        model_cnt++;
        if (exp_q.size() == 0) check_eq("unexpected_move", 64'(mv_data), 64'h7FFFF_FFFF);
        else check_eq("move_data", 64'(mv_data), 64'(exp_q.pop_front()));
      end
      if (gen_done) begin
        gd_cnt++;
        gd_cyc = cyc;
        check_eq("done_all_drained", 64'(exp_q.size()), 64'd0);
        check_eq("done_move_count", 64'(move_count), 64'(sat(model_cnt)));
      end
    end
    pv = mv_valid; pr = mv_ready; pd = mv_data; pab = abort;
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    int g0 = gd_cnt;
    while (gd_cnt == g0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    if (gd_cnt == g0) check_eq("gen_done_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run(input int maxc);
    got.delete();
    do_start();
    wait_done(maxc);
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    @(negedge clk);
    while (!mv_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check_eq("valid_seen", 64'(mv_valid), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_board_reset"}, 64'(board_reset), 64'd0);
    check_eq({tag, "_rden"}, 64'(sq_rden), 64'd0);
    check_eq({tag, "_mv_valid"}, 64'(mv_valid), 64'd0);
    check_eq({tag, "_mv_data"}, 64'(mv_data), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_gen_done"}, 64'(gen_done), 64'd0);
    check_eq({tag, "_move_count"}, 64'(move_count), 64'd0);
    check_eq({tag, "_err_timeout"}, 64'(err_timeout), 64'd0);
    check_eq({tag, "_sq_sel"}, 64'(sq_sel), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t e;
    int r0, b0, g0, s0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; sq_hold = '0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // all squares empty: exact latency 1 + SETTLE + 1 + 64
    cfg.delete();
    r0 = rden_cnt; b0 = br_cnt;
    run(2000);
    check_eq("empty_latency", 64'(gd_cyc - br_cyc), 64'd82);
    check_eq("empty_count", 64'(move_count), 64'd0);
    check_eq("empty_rden", 64'(rden_cnt - r0), 64'd0);
    check_eq("empty_br_cycles", 64'(br_cnt - b0), 64'd1);
    check_eq("empty_busy_after", 64'(busy), 64'd0);

    // square 10, slots 7, 4, 0 valid
    e.sq = 10;
    e.d = blank_entry();
    e.d[19*7 +: 19] = 19'h0A1B2;
    e.d[19*4 +: 19] = 19'h01234;
    e.d[19*0 +: 19] = 19'h00042;
    cfg.delete(); cfg.push_back(e);
    r0 = rden_cnt;
    run(2000);
    check_eq("sq10_n", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      check_eq("sq10_m0", 64'(got[0]), 64'h0A1B2);
      check_eq("sq10_m1", 64'(got[1]), 64'h01234);
      check_eq("sq10_m2", 64'(got[2]), 64'h00042);
    end
    check_eq("sq10_rden", 64'(rden_cnt - r0), 64'd1);
    check_eq("sq10_count", 64'(move_count), 64'd3);

    // same board, consumer stalls 5 cycles on the second move
    mode = 2; stall_left = 5; s0 = stall_cnt;
    run(2000);
    mode = 0;
    check_eq("stall_cycles", 64'(stall_cnt - s0), 64'd5);
    check_eq("stall_n", 64'(got.size()), 64'd3);
    if (got.size() == 3) check_eq("stall_m1", 64'(got[1]), 64'h01234);
    check_eq("stall_count", 64'(move_count), 64'd3);

    // square 63, two full entries
    cfg.delete();
    for (int n = 0; n < 2; n++) begin
      e.sq = 63;
      for (int k = 0; k < 8; k++) e.d[19*k +: 19] = 19'($urandom & 32'h3FFFF);
      cfg.push_back(e);
    end
    r0 = rden_cnt; g0 = gd_cnt;
    run(2000);
    check_eq("sq63_n", 64'(got.size()), 64'd16);
    check_eq("sq63_rden", 64'(rden_cnt - r0), 64'd2);
    check_eq("sq63_count", 64'(move_count), 64'd16);
    check_eq("sq63_done", 64'(gd_cnt - g0), 64'd1);

    // stuck hold: timeout, drain still completes; next start clears the flag
    cfg.delete();
    e.sq = 20; e.d = blank_entry(); e.d[19*2 +: 19] = 19'h15555;
    cfg.push_back(e);
    sq_hold = '0; sq_hold[5] = 1'b1;
    run(3000);
    check_eq("timeout_err", 64'(err_timeout), 64'd1);
    check_eq("timeout_count", 64'(move_count), 64'd1);
    sq_hold = '0;
    got.delete();
    do_start();
    @(posedge clk); #1;
    check_eq("timeout_cleared", 64'(err_timeout), 64'd0);
    wait_done(3000);
    check_eq("timeout_stays_clear", 64'(err_timeout), 64'd0);

    // randomized boards, random consumer, short random hold
    mode = 1;
    for (int it = 0; it < 8; it++) begin
      cfg.delete();
      for (int q = 0; q < NSQ; q++)
        if ($urandom_range(0, 7) == 0)
          for (int n = $urandom_range(1, 2); n > 0; n--) begin
            e.sq = q;
            for (int k = 0; k < 8; k++)
              e.d[19*k +: 19] = 19'({$urandom_range(0, 1) == 0, 18'($urandom)});
            cfg.push_back(e);
          end
      sq_hold = NSQ'(1) << $urandom_range(0, 63);
      hold_left = $urandom_range(1, 40);
      run(5000);
      check_eq("rand_err", 64'(err_timeout), 64'd0);
      check_eq("rand_busy", 64'(busy), 64'd0);
    end

    // async reset in the middle of UNPACK
    mode = 3;
    cfg.delete();
    e.sq = 3;
    for (int k = 0; k < 8; k++) e.d[19*k +: 19] = 19'(k + 1);
    cfg.push_back(e);
    do_start();
    wait_valid(500);
    check_eq("pre_reset_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    @(posedge clk); #1 reset_n = 1'b1;

    // abort in the middle of UNPACK
    g0 = gd_cnt;
    do_start();
    wait_valid(500);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check_eq("abort_valid", 64'(mv_valid), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_rden", 64'(sq_rden), 64'd0);
    repeat (100) @(posedge clk);
    check_eq("abort_no_done", 64'(gd_cnt - g0), 64'd0);

    // abort and start together in IDLE
    b0 = br_cnt;
    @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_start_busy", 64'(busy), 64'd0);
    check_eq("abort_start_no_pulse", 64'(br_cnt - b0), 64'd0);

    // recovery: leftover FIFO contents are replaced by the next load
    mode = 0;
    run(3000);
    check_eq("recover_n", 64'(got.size()), 64'd8);
    check_eq("recover_count", 64'(move_count), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/movegen_sequencer.md
Name: movegen_sequencer

Overview:
Top-level controller for the 64-square move-generation array. On a start request it pulses the board reset into every square unit and waits for propagation to settle. It then drains each square's move FIFO in square order and emits the unpacked 19-bit moves one at a time on a valid/ready stream toward the search engine. A square-indexed mux outside this block supplies the data of the selected square.

Parameters:
NSQ, 64, number of square units; index width is clog2(NSQ).
SETTLE_CYC, 16, minimum cycles after the board reset pulse before draining may start.
MAXWAIT, 255, WAIT-state cycle limit before the timeout error (MAXWAIT > SETTLE_CYC).
RDLAT, 1, cycles from sq_rden to valid sq_data.

Ports:
clk  in  1  clock; all logic rising-edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request to generate moves for the loaded board.
abort  in  1  synchronous abort to IDLE.
board_reset  out  1  reset pulse broadcast to all square units.
sq_hold  in  NSQ  hold outputs of all squares, OR-reduced internally.
sq_empty  in  NSQ  fifoEmpty of each square.
sq_rden  out  NSQ  one-hot fifo read enable.
sq_sel  out  6  index of the square driving sq_data.
sq_data  in  152  muxed fifoOut of the selected square: 8 slots of 19 bits.
mv_data  out  19  move as {7b flag, 6b from, 6b to}; flag bit 18 is invalid.
mv_valid  out  1  mv_data valid.
mv_ready  in  1  consumer accepts.
busy  out  1  high in any state except IDLE.
gen_done  out  1  one-cycle pulse when all FIFOs have been drained.
move_count  out  10  moves emitted this run, saturating at 1023.
err_timeout  out  1  sticky; set when WAIT exceeds MAXWAIT; cleared by start.

Behaviour:
- Async reset (reset_n low): state IDLE; all outputs 0; ptr, counters and the slot buffer cleared.
- States: IDLE, PULSE, WAIT, SCAN, READ, LAT, UNPACK, FIN.
- IDLE: start=1 goes to PULSE, clears move_count and err_timeout, sets ptr=0. start is ignored in every other state.
- PULSE: board_reset=1 for exactly one cycle, then WAIT with the wait counter at 0.
- WAIT: the counter increments each cycle.
  - Exit to SCAN when counter >= SETTLE_CYC and |sq_hold == 0.
  - If the counter reaches MAXWAIT first: set err_timeout and go to SCAN anyway.
- SCAN: sq_sel = ptr.
  - sq_empty[ptr] = 0: go to READ.
  - Else if ptr == NSQ-1: go to FIN.
  - Else ptr++ and stay in SCAN, one cycle per empty square.
- READ: sq_rden[ptr] = 1 for exactly one cycle; all other rden bits 0. Go to LAT.
- LAT: wait RDLAT cycles, then capture sq_data into the 152-bit buffer. Slot k = bits[19k+18:19k]. Set slot index to 7 and go to UNPACK.
- UNPACK: processes slots in order 7 down to 0.
  - Slot invalid (bit 18 = 1): skip in 1 cycle with mv_valid = 0.
  - Slot valid: mv_valid = 1 and mv_data = slot. Both are held stable until mv_ready = 1. On acceptance, move_count++ (saturating) and advance to the next slot.
  - After slot 0 completes, return to SCAN at the same ptr, because a square may hold several entries. sq_empty has settled by then (at least 2 cycles after rden).
- FIN: gen_done = 1 for one cycle, then IDLE. move_count holds until the next start.
- mv_valid is never deasserted without a handshake, except on abort or reset.
- abort=1, any state: next state IDLE; mv_valid, rden and board_reset drop the next cycle; no gen_done.
  - Partially read FIFO contents are left in place; the next start's board_reset is responsible for them.
- Simultaneous abort and start in IDLE: abort wins; stay IDLE.
- No two sq_rden bits are ever high in the same cycle. sq_rden is never asserted while the selected sq_empty = 1.

Test Plan:
- All squares empty, sq_hold = 0: start -> board_reset pulse 1 cycle; gen_done exactly 1+SETTLE_CYC+1+64 cycles later (±1); move_count = 0; no rden.
- Square 10 holds one entry with slots 7, 4 and 0 valid (move values 0x0A1B2, 0x1234, 0x00042), mv_ready = 1 -> exactly three moves in that order; sq_rden[10] high for one cycle; move_count = 3.
- Same stimulus with mv_ready low for 5 cycles on the second move -> mv_data and mv_valid stable for those cycles; no loss; count = 3.
- Square 63 holds two entries of 8 valid moves -> 16 moves; rden pulses twice; gen_done follows; count = 16.
- sq_hold[5] held high -> WAIT lasts until counter = MAXWAIT; err_timeout = 1; drain still completes. A following start clears err_timeout.
- reset_n low mid-UNPACK -> all outputs 0 immediately; IDLE. abort mid-UNPACK -> IDLE next cycle; no gen_done.
